// File: rtl/sum_bcd_converter.sv
// -----------------------------------------------------------------------------
// sum_bcd_converter
//
// Converts the 14-bit binary adder result into packed BCD for the decimal
// display path. This is an iterative double-dabble (shift-and-add-3) converter
// that processes one input bit per clock.
//
// Optional feature macro: SUM_BCD_BLANK_EN
//   When it is defined, the block adds a digit_en output. That output is used
//   to blank leading zeros on the display.
//
// Handshake rule, used on both sides:
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   - Input side: in_ready is high only in IDLE. Upstream keeps in_valid and
//     in_data steady until the transfer. in_data is sampled only on the
//     accepting edge.
//   - Output side: out_valid is high only in DONE. bcd (and digit_en) stay
//     stable until the edge where out_ready is 1.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_data    [WIDTH-1:0]     unsigned binary value from the adder
//   in_valid   in_data is valid
//   in_ready   converter can accept (IDLE)
//   bcd        [4*DIGITS-1:0]  packed BCD; digit 0 (units) in bits [3:0]
//   out_valid  bcd holds a finished conversion (DONE)
//   out_ready  consumer takes bcd
//   busy       conversion in progress (SHIFT)
//   digit_en   [DIGITS-1:0]    (SUM_BCD_BLANK_EN only) digit i is displayed
//
// FSM state is observable via the decoded outputs: in_ready (IDLE),
// busy (SHIFT), out_valid (DONE). Exactly one of them is high at any time.
// -----------------------------------------------------------------------------
module sum_bcd_converter #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
`ifdef SUM_BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     digit_en
`endif
);

  // Shift register layout: {BCD field (4*DIGITS bits), binary field (WIDTH bits)}
  localparam int SW = 4 * DIGITS + WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [SW-1:0]       shift_q, shift_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;

  logic [SW-1:0]       adj;
  logic [SW-1:0]       shifted;
  logic [4*DIGITS-1:0] res_bcd;
  logic                load_result;

  // Add-3 correction. Every nibble is tested on its pre-adjust value, so all
  // digits are corrected in parallel before the single left shift.
  always_comb begin
    adj = shift_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (shift_q[WIDTH+4*i +: 4] >= 4'd5) begin
        adj[WIDTH+4*i +: 4] = shift_q[WIDTH+4*i +: 4] + 4'd3;
      end
    end
  end

  assign shifted     = adj << 1;
  assign res_bcd     = shifted[SW-1 -: 4*DIGITS];
  // The last shift happens on the edge where the counter reads WIDTH-1.
  assign load_result = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shift_d = {{(4*DIGITS){1'b0}}, in_data};
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_d = shifted;
        cnt_d   = cnt_q + 1'b1;
        if (load_result) begin
          bcd_d   = res_bcd;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_SHIFT);
  assign out_valid = (state_q == ST_DONE);
  assign bcd       = bcd_q;

`ifdef SUM_BCD_BLANK_EN
  logic [DIGITS-1:0] digit_en_q, digit_en_d;
  logic [DIGITS-1:0] en_new;
  logic              seen_nz;

  // Scan from the most significant digit downward. A digit is shown once any
  // digit at or above it is nonzero. The units digit is always shown, so the
  // value zero still displays as "0".
  always_comb begin
    seen_nz = 1'b0;
    en_new  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen_nz   = seen_nz | (res_bcd[4*i +: 4] != 4'd0);
      en_new[i] = seen_nz;
    end
    en_new[0] = 1'b1;
  end

  always_comb begin
    digit_en_d = digit_en_q;
    if (load_result) begin
      digit_en_d = en_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_en_q <= {{(DIGITS-1){1'b0}}, 1'b1};
    end else begin
      digit_en_q <= digit_en_d;
    end
  end

  assign digit_en = digit_en_q;
`endif

endmodule
